phase_ramp_gen_v5: RTL

PHASE_RAMP_GEN_V5 -- requirements
Module: phase_ramp_gen_v5

---
 rtl/phase_ramp_pkg.sv | 16 +
 rtl/sat_add_s.sv | 29 ++
 rtl/phase_ramp_gen_v5.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/phase_ramp_pkg.sv
// Shared types and constants for the phase ramp generator.
// The sequencer states and the widths are defined here so the top and the bench agree on them.
package phase_ramp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_WRAP   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_UPDATE = 3'd4
  } state_t;

  localparam int SHIFT_MAX_DEF = 15;
  localparam int DROP_CNT_W    = 8;

endpackage

// File: rtl/sat_add_s.sv
// Signed adder for the phase output. It either saturates to the signed range or wraps modulo 2^W.
module sat_add_s #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_sat_en,
  output logic signed [W-1:0] o_sum
);

  logic signed [W:0]   w_full;
  logic                w_ovf;
  logic signed [W-1:0] w_max;
  logic signed [W-1:0] w_min;

  assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  // Overflow shows up as a mismatch between the extra sign bit and the result sign bit.
  assign w_ovf  = w_full[W] ^ w_full[W-1];
  assign w_max  = {1'b0, {(W-1){1'b1}}};
  assign w_min  = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    o_sum = w_full[W-1:0];
    if (i_sat_en && w_ovf) begin
      o_sum = w_full[W] ? w_min : w_max;
    end
  end

endmodule

// File: rtl/phase_ramp_gen_v5.sv
// Phase ramp generator: a trigger-driven ladder accumulator with an optional 2*pi wrap and a gain shift.
// A modulation word is added every clock to form the phase ramp.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | wait for trigger edge, capture step/gain/wrap settings
// ST_ACCUM  | acc += step (or clear when feedback is off)
// ST_WRAP   | fold acc back into [-lim, lim] by +/- 2*lim, pulse o_wrap
// ST_SCALE  | ladder = acc >>> min(gain_sel, SHIFT_MAX)
// ST_UPDATE | register ladder and shift index to the outputs
module phase_ramp_gen_v5
  import phase_ramp_pkg::*;
#(
  parameter int OUTPUT_BIT = 16,
  parameter int ACC_BIT    = 32,
  parameter int SHIFT_MAX  = SHIFT_MAX_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_trig,
  input  logic signed [ACC_BIT-1:0]    i_step,
  input  logic                         i_fb_on,
  input  logic signed [OUTPUT_BIT-1:0] i_mod,
  input  logic        [3:0]            i_gain_sel,
  input  logic                         i_wrap_en,
  input  logic signed [ACC_BIT-1:0]    i_wrap_lim,
  input  logic                         i_sat_en,
  output logic signed [OUTPUT_BIT-1:0] o_ladderWave,
  output logic signed [OUTPUT_BIT-1:0] o_phaseRamp,
  output logic        [3:0]            o_shift_idx,
  output logic                         o_wrap,
  output logic        [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam logic [3:0] SHIFT_CAP = 4'(SHIFT_MAX);

  state_t                      r_state;
  logic                        r_trig_d;
  logic signed [ACC_BIT-1:0]   r_step;
  logic signed [ACC_BIT-1:0]   r_wrap_lim;
  logic        [3:0]           r_gain_sel;
  logic                        r_wrap_en;
  logic signed [ACC_BIT-1:0]   r_acc;
  logic signed [OUTPUT_BIT-1:0] r_ladder;
  logic        [3:0]           r_shift;
  logic signed [OUTPUT_BIT-1:0] r_ladder_out;
  logic        [3:0]           r_shift_idx;
  logic                        r_wrap;
  logic        [DROP_CNT_W-1:0] r_drop_cnt;
  logic signed [OUTPUT_BIT-1:0] r_phase;

  logic                         w_trig_edge;
  logic        [3:0]            w_shift;
  logic signed [ACC_BIT-1:0]    w_two_lim;
  logic signed [OUTPUT_BIT-1:0] w_sum;
  logic signed [OUTPUT_BIT-1:0] w_phase_next;

  assign w_trig_edge  = i_trig & ~r_trig_d;
  assign w_shift      = (r_gain_sel > SHIFT_CAP) ? SHIFT_CAP : r_gain_sel;
  // The limit is kept below 2^(ACC_BIT-2), so doubling it cannot overflow.
  assign w_two_lim    = r_wrap_lim <<< 1;
  assign w_phase_next = i_fb_on ? w_sum : i_mod;

  sat_add_s #(
    .W (OUTPUT_BIT)
  ) u_sat_add (
    .i_a      (r_ladder_out),
    .i_b      (i_mod),
    .i_sat_en (i_sat_en),
    .o_sum    (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_trig_d     <= 1'b0;
      r_step       <= '0;
      r_wrap_lim   <= '0;
      r_gain_sel   <= '0;
      r_wrap_en    <= 1'b0;
      r_acc        <= '0;
      r_ladder     <= '0;
      r_shift      <= '0;
      r_ladder_out <= '0;
      r_shift_idx  <= '0;
      r_wrap       <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_trig_d <= i_trig;
      r_wrap   <= 1'b0;

      if (w_trig_edge && (r_state != ST_IDLE) && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_trig_edge) begin
            r_step     <= i_step;
            r_gain_sel <= i_gain_sel;
            r_wrap_en  <= i_wrap_en;
            r_wrap_lim <= i_wrap_lim;
            r_state    <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc   <= i_fb_on ? (r_acc + r_step) : '0;
          r_state <= ST_WRAP;
        end
        ST_WRAP: begin
          if (r_wrap_en) begin
            if (r_acc > r_wrap_lim) begin
              r_acc  <= r_acc - w_two_lim;
              r_wrap <= 1'b1;
            end else if (r_acc < -r_wrap_lim) begin
              r_acc  <= r_acc + w_two_lim;
              r_wrap <= 1'b1;
            end
          end
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_ladder <= OUTPUT_BIT'(r_acc >>> w_shift);
          r_shift  <= w_shift;
          r_state  <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_ladder_out <= r_ladder;
          r_shift_idx  <= r_shift;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  assign o_ladderWave = r_ladder_out;
  assign o_phaseRamp  = r_phase;
  assign o_shift_idx  = r_shift_idx;
  assign o_wrap       = r_wrap;
  assign o_drop_cnt   = r_drop_cnt;

endmodule
